// File: rtl/rat_pkg.sv
// Shared RAT core definitions: opcodes, ALU selects, FSM states and datapath mux codes.
package rat_pkg;

  typedef enum logic [1:0] {ST_INIT, ST_FETCH, ST_EXEC, ST_INTR} state_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_ADDC, ALU_SUB, ALU_SUBC, ALU_CMP, ALU_AND, ALU_OR, ALU_EXOR,
    ALU_TEST, ALU_LSL, ALU_LSR, ALU_ROL, ALU_ROR, ALU_ASR, ALU_MOV = 4'd14, ALU_NONE = 4'd15
  } alu_sel_t;

  // Register forms, full 7-bit opcode {HI_5, LOW_2}
  localparam logic [6:0] OP_AND = 7'b0000000, OP_OR = 7'b0000001, OP_EXOR = 7'b0000010,
    OP_TEST = 7'b0000011, OP_ADD = 7'b0000100, OP_ADDC = 7'b0000101, OP_SUB = 7'b0000110,
    OP_SUBC = 7'b0000111, OP_CMP = 7'b0001000, OP_MOV = 7'b0001001, OP_LD = 7'b0001010,
    OP_ST = 7'b0001011, OP_BRN = 7'b0010000, OP_CALL = 7'b0010001, OP_BREQ = 7'b0010010,
    OP_BRNE = 7'b0010011, OP_BRCS = 7'b0010100, OP_BRCC = 7'b0010101, OP_LSL = 7'b0100000,
    OP_LSR = 7'b0100001, OP_ROL = 7'b0100010, OP_ROR = 7'b0100011, OP_ASR = 7'b0100100,
    OP_PUSH = 7'b0100101, OP_POP = 7'b0100110, OP_WSP = 7'b0101000, OP_CLC = 7'b0110000,
    OP_SEC = 7'b0110001, OP_RET = 7'b0110010, OP_SEI = 7'b0110100, OP_CLI = 7'b0110101,
    OP_RETID = 7'b0110110, OP_RETIE = 7'b0110111;

  // Immediate forms, decoded on HI_5 only
  localparam logic [4:0] OPI_AND = 5'b10000, OPI_OR = 5'b10001, OPI_EXOR = 5'b10010,
    OPI_TEST = 5'b10011, OPI_ADD = 5'b10100, OPI_ADDC = 5'b10101, OPI_SUB = 5'b10110,
    OPI_SUBC = 5'b10111, OPI_CMP = 5'b11000, OPI_IN = 5'b11001, OPI_OUT = 5'b11010,
    OPI_MOV = 5'b11011, OPI_LD = 5'b11100, OPI_ST = 5'b11101;

  localparam logic [1:0] PC_SEL_IMM = 2'd0, PC_SEL_SCR = 2'd1, PC_SEL_VEC = 2'd2;
  localparam logic [1:0] RF_SEL_ALU = 2'd0, RF_SEL_SCR = 2'd1, RF_SEL_IN = 2'd3;
  localparam logic [1:0] SCR_A_DY = 2'd0, SCR_A_IMM = 2'd1, SCR_A_SP = 2'd2, SCR_A_SPM1 = 2'd3;
  localparam logic SCR_D_DX = 1'b0, SCR_D_PC = 1'b1;

  function automatic alu_sel_t alu_decode(input logic [4:0] hi5, input logic [1:0] lo2);
    alu_sel_t sel;
    sel = ALU_NONE;
    if (hi5[4]) begin
      case (hi5)
        OPI_AND:  sel = ALU_AND;
        OPI_OR:   sel = ALU_OR;
        OPI_EXOR: sel = ALU_EXOR;
        OPI_TEST: sel = ALU_TEST;
        OPI_ADD:  sel = ALU_ADD;
        OPI_ADDC: sel = ALU_ADDC;
        OPI_SUB:  sel = ALU_SUB;
        OPI_SUBC: sel = ALU_SUBC;
        OPI_CMP:  sel = ALU_CMP;
        OPI_MOV:  sel = ALU_MOV;
        default:  sel = ALU_NONE;
      endcase
    end else begin
      case ({hi5, lo2})
        OP_AND:  sel = ALU_AND;
        OP_OR:   sel = ALU_OR;
        OP_EXOR: sel = ALU_EXOR;
        OP_TEST: sel = ALU_TEST;
        OP_ADD:  sel = ALU_ADD;
        OP_ADDC: sel = ALU_ADDC;
        OP_SUB:  sel = ALU_SUB;
        OP_SUBC: sel = ALU_SUBC;
        OP_CMP:  sel = ALU_CMP;
        OP_MOV:  sel = ALU_MOV;
        OP_LSL:  sel = ALU_LSL;
        OP_LSR:  sel = ALU_LSR;
        OP_ROL:  sel = ALU_ROL;
        OP_ROR:  sel = ALU_ROR;
        OP_ASR:  sel = ALU_ASR;
        default: sel = ALU_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/rat_control_core_if.sv
// Instruction/flag inputs, ALU operands and all control strobes of the RAT core.
interface rat_control_core_if;
  logic [4:0] OPCODE_HI_5;
  logic [1:0] OPCODE_LOW_2;
  logic       INT, C_FLAG, Z_FLAG;
  logic [7:0] A, B, RESULT;
  logic       C, Z, PC_LD, PC_INC, ALU_OPY_SEL, RF_WR;
  logic [1:0] PC_MUX_SEL, RF_WR_SEL, SCR_ADDR_SEL;
  logic       FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL, FLG_SHAD_LD;
  logic       SP_LD, SP_INCR, SP_DECR, SCR_WE, SCR_DATA_SEL, RST, IO_STRB, I_OUT;

  modport master (
    input  OPCODE_HI_5, OPCODE_LOW_2, INT, C_FLAG, Z_FLAG, A, B,
    output RESULT, C, Z, PC_LD, PC_INC, PC_MUX_SEL, ALU_OPY_SEL, RF_WR, RF_WR_SEL,
           FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL, FLG_SHAD_LD,
           SP_LD, SP_INCR, SP_DECR, SCR_WE, SCR_ADDR_SEL, SCR_DATA_SEL, RST, IO_STRB, I_OUT
  );

  modport slave (
    output OPCODE_HI_5, OPCODE_LOW_2, INT, C_FLAG, Z_FLAG, A, B,
    input  RESULT, C, Z, PC_LD, PC_INC, PC_MUX_SEL, ALU_OPY_SEL, RF_WR, RF_WR_SEL,
           FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL, FLG_SHAD_LD,
           SP_LD, SP_INCR, SP_DECR, SCR_WE, SCR_ADDR_SEL, SCR_DATA_SEL, RST, IO_STRB, I_OUT
  );
endinterface

// File: rtl/rat_alu.sv
// Combinational 8-bit ALU; subtract forms report borrow on carry-out.
module rat_alu
  import rat_pkg::*;
(
  input  alu_sel_t   sel_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] result_o,
  output logic       c_o,
  output logic       z_o
);

  always_comb begin
    result_o = 8'h00;
    c_o      = 1'b0;
    case (sel_i)
      ALU_ADD:           {c_o, result_o} = {1'b0, a_i} + {1'b0, b_i};
      ALU_ADDC:          {c_o, result_o} = {1'b0, a_i} + {1'b0, b_i} + {8'h00, cin_i};
      ALU_SUB, ALU_CMP:  {c_o, result_o} = {1'b0, a_i} - {1'b0, b_i};
      ALU_SUBC:          {c_o, result_o} = {1'b0, a_i} - {1'b0, b_i} - {8'h00, cin_i};
      ALU_AND, ALU_TEST: result_o = a_i & b_i;
      ALU_OR:            result_o = a_i | b_i;
      ALU_EXOR:          result_o = a_i ^ b_i;
      ALU_LSL:           {c_o, result_o} = {a_i, cin_i};
      ALU_LSR:           {result_o, c_o} = {cin_i, a_i};
      ALU_ROL:           begin result_o = {a_i[6:0], a_i[7]}; c_o = a_i[7]; end
      ALU_ROR:           begin result_o = {a_i[0], a_i[7:1]}; c_o = a_i[0]; end
      ALU_ASR:           begin result_o = {a_i[7], a_i[7:1]}; c_o = a_i[0]; end
      ALU_MOV:           result_o = b_i;
      default:           result_o = 8'h00;
    endcase
  end

  assign z_o = (result_o == 8'h00);

endmodule

// File: rtl/rat_control_core.sv
// RAT MCU control core: instruction sequencing FSM, interrupt-enable bit and ALU.
//   state    | meaning
//   ST_INIT  | datapath reset (RST) for one cycle after reset release
//   ST_FETCH | PC increment while the instruction register loads
//   ST_EXEC  | decode and execute the current opcode
//   ST_INTR  | vector to 0x3FF, push PC, shadow flags, disable interrupts
module rat_control_core
  import rat_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  rat_control_core_if.master bus
);

  state_t     state_q;
  logic       i_q, i_set, i_clr;
  logic [6:0] op7;

  assign op7       = {bus.OPCODE_HI_5, bus.OPCODE_LOW_2};
  assign bus.I_OUT = i_q;

  rat_alu u_alu (
    .sel_i   (alu_decode(bus.OPCODE_HI_5, bus.OPCODE_LOW_2)),
    .a_i     (bus.A),
    .b_i     (bus.B),
    .cin_i   (bus.C_FLAG),
    .result_o(bus.RESULT),
    .c_o     (bus.C),
    .z_o     (bus.Z)
  );

  // Interrupt decision uses i_q before this EXEC's SEI/CLI lands.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_INIT;
      i_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT:  state_q <= ST_FETCH;
        ST_FETCH: state_q <= ST_EXEC;
        ST_EXEC:  state_q <= (bus.INT && i_q) ? ST_INTR : ST_FETCH;
        default:  state_q <= ST_FETCH;
      endcase
      if (i_clr)      i_q <= 1'b0;
      else if (i_set) i_q <= 1'b1;
    end
  end

  always_comb begin
    bus.PC_LD = 1'b0;      bus.PC_INC = 1'b0;      bus.PC_MUX_SEL = PC_SEL_IMM;
    bus.ALU_OPY_SEL = 1'b0; bus.RF_WR = 1'b0;      bus.RF_WR_SEL = RF_SEL_ALU;
    bus.FLG_C_SET = 1'b0;  bus.FLG_C_CLR = 1'b0;   bus.FLG_C_LD = 1'b0;
    bus.FLG_Z_LD = 1'b0;   bus.FLG_LD_SEL = 1'b0;  bus.FLG_SHAD_LD = 1'b0;
    bus.SP_LD = 1'b0;      bus.SP_INCR = 1'b0;     bus.SP_DECR = 1'b0;
    bus.SCR_WE = 1'b0;     bus.SCR_ADDR_SEL = SCR_A_DY; bus.SCR_DATA_SEL = SCR_D_DX;
    bus.RST = 1'b0;        bus.IO_STRB = 1'b0;
    i_set = 1'b0;          i_clr = 1'b0;

    case (state_q)
      ST_INIT:  bus.RST = 1'b1;
      ST_FETCH: bus.PC_INC = 1'b1;
      ST_INTR: begin
        bus.PC_LD = 1'b1; bus.PC_MUX_SEL = PC_SEL_VEC;
        bus.SCR_WE = 1'b1; bus.SCR_DATA_SEL = SCR_D_PC; bus.SCR_ADDR_SEL = SCR_A_SPM1;
        bus.SP_DECR = 1'b1; bus.FLG_SHAD_LD = 1'b1; i_clr = 1'b1;
      end
      default: begin
        if (bus.OPCODE_HI_5[4]) begin
          case (bus.OPCODE_HI_5)
            OPI_AND, OPI_OR, OPI_EXOR, OPI_ADD, OPI_ADDC, OPI_SUB, OPI_SUBC: begin
              bus.ALU_OPY_SEL = 1'b1; bus.RF_WR = 1'b1; bus.FLG_C_LD = 1'b1; bus.FLG_Z_LD = 1'b1;
            end
            OPI_TEST, OPI_CMP: begin
              bus.ALU_OPY_SEL = 1'b1; bus.FLG_C_LD = 1'b1; bus.FLG_Z_LD = 1'b1;
            end
            OPI_MOV: begin bus.ALU_OPY_SEL = 1'b1; bus.RF_WR = 1'b1; end
            OPI_IN:  begin bus.RF_WR = 1'b1; bus.RF_WR_SEL = RF_SEL_IN; end
            OPI_OUT: bus.IO_STRB = 1'b1;
            OPI_LD: begin
              bus.RF_WR = 1'b1; bus.RF_WR_SEL = RF_SEL_SCR; bus.SCR_ADDR_SEL = SCR_A_IMM;
            end
            OPI_ST:  begin bus.SCR_WE = 1'b1; bus.SCR_ADDR_SEL = SCR_A_IMM; end
            default: ;
          endcase
        end else begin
          case (op7)
            OP_AND, OP_OR, OP_EXOR, OP_ADD, OP_ADDC, OP_SUB, OP_SUBC,
            OP_LSL, OP_LSR, OP_ROL, OP_ROR, OP_ASR: begin
              bus.RF_WR = 1'b1; bus.FLG_C_LD = 1'b1; bus.FLG_Z_LD = 1'b1;
            end
            OP_TEST, OP_CMP: begin bus.FLG_C_LD = 1'b1; bus.FLG_Z_LD = 1'b1; end
            OP_MOV:  bus.RF_WR = 1'b1;
            OP_LD:   begin bus.RF_WR = 1'b1; bus.RF_WR_SEL = RF_SEL_SCR; end
            OP_ST:   bus.SCR_WE = 1'b1;
            OP_BRN:  bus.PC_LD = 1'b1;
            OP_BREQ: bus.PC_LD = bus.Z_FLAG;
            OP_BRNE: bus.PC_LD = !bus.Z_FLAG;
            OP_BRCS: bus.PC_LD = bus.C_FLAG;
            OP_BRCC: bus.PC_LD = !bus.C_FLAG;
            OP_CALL: begin
              bus.PC_LD = 1'b1; bus.SCR_WE = 1'b1; bus.SCR_DATA_SEL = SCR_D_PC;
              bus.SCR_ADDR_SEL = SCR_A_SPM1; bus.SP_DECR = 1'b1;
            end
            OP_PUSH: begin bus.SCR_WE = 1'b1; bus.SCR_ADDR_SEL = SCR_A_SPM1; bus.SP_DECR = 1'b1; end
            OP_POP: begin
              bus.RF_WR = 1'b1; bus.RF_WR_SEL = RF_SEL_SCR;
              bus.SCR_ADDR_SEL = SCR_A_SP; bus.SP_INCR = 1'b1;
            end
            OP_WSP:  bus.SP_LD = 1'b1;
            OP_CLC:  bus.FLG_C_CLR = 1'b1;
            OP_SEC:  bus.FLG_C_SET = 1'b1;
            OP_SEI:  i_set = 1'b1;
            OP_CLI:  i_clr = 1'b1;
            OP_RET, OP_RETID, OP_RETIE: begin
              bus.PC_LD = 1'b1; bus.PC_MUX_SEL = PC_SEL_SCR;
              bus.SCR_ADDR_SEL = SCR_A_SP; bus.SP_INCR = 1'b1;
              if (op7 != OP_RET) begin
                bus.FLG_LD_SEL = 1'b1; bus.FLG_C_LD = 1'b1; bus.FLG_Z_LD = 1'b1;
                i_set = (op7 == OP_RETIE);
                i_clr = (op7 == OP_RETID);
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

endmodule

// File: tb/tb_rat_control_core.sv
// Scoreboard bench for rat_control_core: per-cycle expected controls/ALU queued by the driver.
module tb_rat_control_core;

  typedef struct packed {
    logic       pc_ld, pc_inc;
    logic [1:0] pc_mux;
    logic       opy, rf_wr;
    logic [1:0] rf_sel;
    logic       c_set, c_clr, c_ld, z_ld, ld_sel, shad_ld, sp_ld, sp_inc, sp_dec, scr_we;
    logic [1:0] scr_addr;
    logic       scr_data, rst, io, i_out;
  } ctl_t;

  typedef struct {
    string      tag;
    ctl_t       ctl;
    bit         chk_alu;
    logic [9:0] alu;   // {C, Z, RESULT}
  } sb_item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   n_chk = 0;
  bit   exp_i = 1'b0;
  sb_item_t sb_q[$];
  sb_item_t mon_it;
  ctl_t e;

  rat_control_core_if bus ();

  rat_control_core dut (
    .CLK  (clk),
    .RESET(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, obs, expv);
    end
  endtask

  function automatic ctl_t get_ctl();
    ctl_t c;
    c = {bus.PC_LD, bus.PC_INC, bus.PC_MUX_SEL, bus.ALU_OPY_SEL, bus.RF_WR, bus.RF_WR_SEL,
         bus.FLG_C_SET, bus.FLG_C_CLR, bus.FLG_C_LD, bus.FLG_Z_LD, bus.FLG_LD_SEL,
         bus.FLG_SHAD_LD, bus.SP_LD, bus.SP_INCR, bus.SP_DECR, bus.SCR_WE, bus.SCR_ADDR_SEL,
         bus.SCR_DATA_SEL, bus.RST, bus.IO_STRB, bus.I_OUT};
    return c;
  endfunction

  function automatic ctl_t z_ctl();
    ctl_t c;
    c = '0;
    c.i_out = exp_i;
    return c;
  endfunction

  function automatic ctl_t alu_c(input bit opy, input bit wr);
    ctl_t c;
    c = '0;
    c.opy = opy; c.rf_wr = wr; c.c_ld = 1'b1; c.z_ld = 1'b1;
    return c;
  endfunction

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_it = sb_q.pop_front();
      chk(mon_it.tag, 32'(get_ctl()), 32'(mon_it.ctl));
      if (mon_it.chk_alu)
        chk({mon_it.tag, "_alu"}, 32'({bus.C, bus.Z, bus.RESULT}), 32'(mon_it.alu));
    end
  end

  task automatic cyc(input string tag, input ctl_t ex, input bit ca, input logic [9:0] alu);
    sb_item_t it;
    it.tag = tag; it.ctl = ex; it.chk_alu = ca; it.alu = alu;
    sb_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input string tag, input logic [6:0] op, input logic [7:0] a,
                       input logic [7:0] b, input bit cf, input bit zf, input bit intr,
                       input ctl_t ex, input bit ca, input logic [9:0] alu,
                       input bit new_i, input bit take);
    ctl_t f;
    bus.OPCODE_HI_5 = op[6:2]; bus.OPCODE_LOW_2 = op[1:0];
    bus.A = a; bus.B = b; bus.C_FLAG = cf; bus.Z_FLAG = zf; bus.INT = intr;
    f = z_ctl(); f.pc_inc = 1'b1;
    cyc({tag, "_fetch"}, f, 1'b0, '0);
    ex.i_out = exp_i;
    cyc(tag, ex, ca, alu);
    exp_i = new_i;
    if (take) begin
      f = z_ctl(); f.pc_ld = 1'b1; f.pc_mux = 2'd2; f.scr_we = 1'b1; f.scr_data = 1'b1;
      f.scr_addr = 2'd3; f.sp_dec = 1'b1; f.shad_ld = 1'b1;
      cyc({tag, "_intr"}, f, 1'b0, '0);
      exp_i = 1'b0;
    end
    bus.INT = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errs, n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    bus.OPCODE_HI_5 = '0; bus.OPCODE_LOW_2 = '0; bus.INT = 1'b0;
    bus.C_FLAG = 1'b0; bus.Z_FLAG = 1'b0; bus.A = '0; bus.B = '0;
    @(posedge clk); #1;
    e = z_ctl(); e.rst = 1'b1;
    cyc("reset", e, 1'b0, '0);
    rst_n = 1'b1;
    cyc("init", e, 1'b0, '0);

    instr("add", 7'b0000100, 8'hFF, 8'h01, 1, 0, 0, alu_c(0, 1), 1, {1'b1, 1'b1, 8'h00}, 0, 0);
    instr("subc_i", {5'b10111, 2'b10}, 8'h10, 8'h10, 1, 0, 0, alu_c(1, 1), 1, {1'b1, 1'b0, 8'hFF}, 0, 0);
    instr("cmp", 7'b0001000, 8'h05, 8'h07, 0, 0, 0, alu_c(0, 0), 1, {1'b1, 1'b0, 8'hFE}, 0, 0);
    instr("and_i", {5'b10000, 2'b11}, 8'hF0, 8'h3C, 1, 0, 0, alu_c(1, 1), 1, {1'b0, 1'b0, 8'h30}, 0, 0);
    instr("ror", 7'b0100011, 8'h01, 8'h00, 0, 0, 0, alu_c(0, 1), 1, {1'b1, 1'b0, 8'h80}, 0, 0);
    instr("lsl", 7'b0100000, 8'h80, 8'h00, 0, 0, 0, alu_c(0, 1), 1, {1'b1, 1'b1, 8'h00}, 0, 0);
    instr("lsr", 7'b0100001, 8'h01, 8'h00, 1, 0, 0, alu_c(0, 1), 1, {1'b1, 1'b0, 8'h80}, 0, 0);
    instr("asr", 7'b0100100, 8'h81, 8'h00, 0, 0, 0, alu_c(0, 1), 1, {1'b1, 1'b0, 8'hC0}, 0, 0);

    e = '0;
    instr("breq_z0", 7'b0010010, 8'h00, 8'h00, 0, 0, 0, e, 0, '0, 0, 0);
    e = '0; e.pc_ld = 1'b1;
    instr("breq_z1", 7'b0010010, 8'h00, 8'h00, 0, 1, 0, e, 0, '0, 0, 0);
    instr("brcc_c0", 7'b0010101, 8'h00, 8'h00, 0, 0, 0, e, 0, '0, 0, 0);
    e = '0;
    instr("brcs_c0", 7'b0010100, 8'h00, 8'h00, 0, 0, 0, e, 0, '0, 0, 0);
    e = '0; e.pc_ld = 1'b1; e.scr_we = 1'b1; e.scr_data = 1'b1; e.scr_addr = 2'd3; e.sp_dec = 1'b1;
    instr("call", 7'b0010001, 8'h00, 8'h00, 0, 0, 0, e, 0, '0, 0, 0);
    e = '0; e.scr_we = 1'b1; e.scr_addr = 2'd1;
    instr("st_i", {5'b11101, 2'b01}, 8'h00, 8'h00, 0, 0, 0, e, 0, '0, 0, 0);
    e = '0; e.rf_wr = 1'b1; e.rf_sel = 2'd1;
    instr("ld", 7'b0001010, 8'h00, 8'h00, 0, 0, 0, e, 0, '0, 0, 0);
    e = '0; e.rf_wr = 1'b1; e.rf_sel = 2'd3;
    instr("in", {5'b11001, 2'b00}, 8'h00, 8'h00, 0, 0, 0, e, 0, '0, 0, 0);
    e = '0; e.io = 1'b1;
    instr("out", {5'b11010, 2'b00}, 8'h00, 8'h00, 0, 0, 0, e, 0, '0, 0, 0);
    e = '0; e.scr_we = 1'b1; e.scr_addr = 2'd3; e.sp_dec = 1'b1;
    instr("push", 7'b0100101, 8'h00, 8'h00, 0, 0, 0, e, 0, '0, 0, 0);
    e = '0; e.rf_wr = 1'b1; e.rf_sel = 2'd1; e.scr_addr = 2'd2; e.sp_inc = 1'b1;
    instr("pop", 7'b0100110, 8'h00, 8'h00, 0, 0, 0, e, 0, '0, 0, 0);
    e = '0; e.sp_ld = 1'b1;
    instr("wsp", 7'b0101000, 8'h00, 8'h00, 0, 0, 0, e, 0, '0, 0, 0);
    e = '0; e.c_set = 1'b1;
    instr("sec", 7'b0110001, 8'h00, 8'h00, 0, 0, 0, e, 0, '0, 0, 0);
    e = '0;
    instr("nop", 7'b0111111, 8'h00, 8'h00, 0, 0, 1, e, 0, '0, 0, 0);

    // Interrupt flow: SEI with I=0 never interrupts, the next EXEC does.
    e = '0;
    instr("sei_int", 7'b0110100, 8'h00, 8'h00, 0, 0, 1, e, 0, '0, 1, 0);
    e = '0; e.rf_wr = 1'b1;
    instr("mov_int", 7'b0001001, 8'h33, 8'h5A, 0, 0, 1, e, 1, {1'b0, 1'b0, 8'h5A}, 1, 1);
    e = '0; e.pc_ld = 1'b1; e.pc_mux = 2'd1; e.scr_addr = 2'd2; e.sp_inc = 1'b1;
    e.ld_sel = 1'b1; e.c_ld = 1'b1; e.z_ld = 1'b1;
    instr("retie", 7'b0110111, 8'h00, 8'h00, 0, 0, 0, e, 0, '0, 1, 0);
    e = '0;
    instr("cli_int", 7'b0110101, 8'h00, 8'h00, 0, 0, 1, e, 0, '0, 0, 1);
    instr("sei", 7'b0110100, 8'h00, 8'h00, 0, 0, 0, e, 0, '0, 1, 0);
    e = '0; e.pc_ld = 1'b1; e.pc_mux = 2'd1; e.scr_addr = 2'd2; e.sp_inc = 1'b1;
    e.ld_sel = 1'b1; e.c_ld = 1'b1; e.z_ld = 1'b1;
    instr("retid", 7'b0110110, 8'h00, 8'h00, 0, 0, 0, e, 0, '0, 0, 0);
    e = '0;
    instr("sei2", 7'b0110100, 8'h00, 8'h00, 0, 0, 0, e, 0, '0, 1, 0);

    // Abort an instruction mid-EXEC with reset.
    bus.OPCODE_HI_5 = 5'b00001; bus.OPCODE_LOW_2 = 2'b00;
    e = z_ctl(); e.pc_inc = 1'b1;
    cyc("abort_fetch", e, 1'b0, '0);
    rst_n = 1'b0;
    exp_i = 1'b0;
    e = z_ctl(); e.rst = 1'b1;
    cyc("abort_rst", e, 1'b0, '0);
    rst_n = 1'b1;
    cyc("abort_init", e, 1'b0, '0);
    e = '0;
    instr("post_rst", 7'b0111111, 8'h00, 8'h00, 0, 0, 1, e, 0, '0, 0, 0);

    @(negedge clk);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end

endmodule
